ifu_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle core's decode/execute logic. It replaces the combinational instruction read with a handshaked memory request/response path. It holds the fetch PC, issues 8-byte-aligned reads, and selects the 32-bit instruction half by `pc[2]`. It delivers `{inst, inst_pc}` to the consumer over a valid/ready interface and accepts redirects from the branch/interrupt logic.

---
 rtl/ifu_fetch.sv | 165 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage in front of the core's decode/execute.
// Holds the fetch PC and issues 8-byte-aligned memory reads, one at a time.
// The 32-bit half of the returned line is chosen by pc[2]. The whole line is
// kept in a one-entry buffer, so the second half is delivered without a
// second memory access. Redirects from the branch/interrupt logic replace the
// PC. A response that belongs to a request made before a redirect is dropped.
//
// Ports
//   clk             single clock, rising edge
//   rst             asynchronous reset, active low
//   redirect_valid  replace the fetch PC with redirect_pc
//   redirect_pc     redirect target; bits [1:0] are forced to zero
//   mem_req_valid   read request valid
//   mem_req_ready   memory accepts the request
//   mem_req_addr    8-byte aligned read address {pc[63:3], 3'b000}
//   mem_resp_valid  one-cycle pulse carrying read data
//   mem_resp_data   64-bit read data
//   inst_valid      instruction available to the consumer
//   inst_ready      consumer takes the instruction
//   inst            instruction word
//   inst_pc         PC of inst
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | held in reset; leaves on the first edge after release
// REQ   | read request presented, waiting for mem_req_ready
// WAIT  | one request in flight, waiting for mem_resp_valid
// OUT   | instruction presented, waiting for inst_ready

module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] lb_data;
  logic [60:0] lb_tag;
  logic        lb_valid;
  logic        drop;

  logic [63:0] pc_inc;
  logic [63:0] redir_pc;
  logic        lb_hit;

  assign pc_inc       = pc + 64'd4;
  assign redir_pc     = redirect_pc & ~64'h3;
  assign mem_req_addr = {pc[63:3], 3'b000};

  // The upper half of the buffered line can be delivered without a new read.
  // This holds only when the current PC is the lower half of that same line.
  assign lb_hit = lb_valid && !pc[2] && (lb_tag == pc[63:3]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      lb_data       <= 64'h0;
      lb_tag        <= 61'h0;
      lb_valid      <= 1'b0;
      drop          <= 1'b0;
      mem_req_valid <= 1'b0;
      inst_valid    <= 1'b0;
      inst          <= 32'h0;
      inst_pc       <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          // Responses still arriving from before the reset are ignored here.
          state         <= REQ;
          mem_req_valid <= 1'b1;
        end

        REQ: begin
          if (redirect_valid) begin
            pc       <= redir_pc;
            lb_valid <= 1'b0;
          end
          if (mem_req_ready) begin
            // A request accepted in the same cycle as a redirect targets the
            // old PC, so its response has to be discarded.
            if (redirect_valid) begin
              drop <= 1'b1;
            end
            state         <= WAIT;
            mem_req_valid <= 1'b0;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            pc       <= redir_pc;
            lb_valid <= 1'b0;
          end
          if (mem_resp_valid) begin
            if (drop || redirect_valid) begin
              drop          <= 1'b0;
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end else begin
              lb_data    <= mem_resp_data;
              lb_tag     <= pc[63:3];
              lb_valid   <= 1'b1;
              inst       <= pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= OUT;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end

        OUT: begin
          if (redirect_valid) begin
            // A handshake in this cycle still completes, but the next fetch
            // starts from the redirect target instead of pc+4.
            pc            <= redir_pc;
            lb_valid      <= 1'b0;
            inst_valid    <= 1'b0;
            state         <= REQ;
            mem_req_valid <= 1'b1;
          end else if (inst_ready) begin
            pc <= pc_inc;
            if (lb_hit) begin
              inst    <= lb_data[63:32];
              inst_pc <= pc_inc;
            end else begin
              inst_valid    <= 1'b0;
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end
          end
        end

        default: begin
          state         <= IDLE;
          mem_req_valid <= 1'b0;
          inst_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch. It has three processes:
//   - a memory model with a programmable ready stall and response latency,
//   - a monitor that compares each inst handshake with a queue of expected
//     instructions,
//   - a directed stimulus sequence that pushes those expectations and checks
//     request, timing and reset behaviour.

module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] i;
    logic [63:0] p;
  } exp_t;
  exp_t exp_q[$];

  // memory model controls, written by the stimulus
  int lat        = 1;
  int stall_left = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    case (a)
      64'h8000_0000: mem_rd = 64'h00000297_00100513;
      64'h8000_0008: mem_rd = 64'h11111111_22222222;
      64'h8000_0100: mem_rd = 64'hAAAA0001_BBBB0002;
      64'h8000_0108: mem_rd = 64'hCCCC0003_DDDD0004;
      64'h8000_0200: mem_rd = 64'h00000013_12345678;
      default:       mem_rd = 64'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] p);
    exp_t e;
    e.i = i;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_req_valid"},  {63'b0, mem_req_valid}, 64'd0);
    chk({tag, "_inst_valid"}, {63'b0, inst_valid},    64'd0);
    chk({tag, "_req_addr"},   mem_req_addr,           64'h8000_0000);
    chk({tag, "_inst"},       {32'b0, inst},          64'd0);
    chk({tag, "_inst_pc"},    inst_pc,                64'h8000_0000);
  endtask

  // Waits, up to a cycle budget, for a request to the given address.
  task automatic wait_req(input string name, input logic [63:0] addr);
    int n;
    n = 0;
    while (!(mem_req_valid && mem_req_addr == addr) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, mem_req_valid ? mem_req_addr : 64'hFFFF_FFFF_FFFF_FFFF, addr);
  endtask

  // memory model: samples the request handshake mid-cycle, drives after edge
  logic        s_v, s_r;
  logic [63:0] s_a;
  logic        pend = 1'b0;
  int          cnt  = 0;
  logic [63:0] pend_addr;

  initial begin
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 64'h0;
    forever begin
      @(negedge clk);
      s_v = mem_req_valid;
      s_r = mem_req_ready;
      s_a = mem_req_addr;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (s_v && !s_r && stall_left > 0) stall_left--;
      if (s_v && s_r) begin
        pend      = 1'b1;
        cnt       = lat;
        pend_addr = s_a;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_rd(pend_addr);
          pend           = 1'b0;
        end
      end
      mem_req_ready = (stall_left == 0);
    end
  end

  // scoreboard monitor: every completed inst handshake pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && inst_valid && inst_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_inst actual inst=%h pc=%h required no delivery", inst, inst_pc);
        end else begin
          e = exp_q.pop_front();
          if (inst !== e.i || inst_pc !== e.p) begin
            failures++;
            $display("FAIL inst_stream actual inst=%h pc=%h required inst=%h pc=%h",
                     inst, inst_pc, e.i, e.p);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    inst_ready     = 1'b1;

    repeat (2) @(negedge clk);
    reset_vals("reset");

    // sequential fetch: miss, buffer hit, then miss on the next line
    push(32'h00100513, 64'h8000_0000);
    push(32'h00000297, 64'h8000_0004);
    rst = 1'b1;
    #1 chk("req_before_first_edge", {63'b0, mem_req_valid}, 64'd0);
    @(negedge clk);
    chk("first_req_valid", {63'b0, mem_req_valid}, 64'd1);
    chk("first_req_addr",  mem_req_addr, 64'h8000_0000);
    @(negedge clk);
    chk("wait_no_inst", {63'b0, inst_valid}, 64'd0);
    @(negedge clk);
    chk("first_inst_valid_k1", {63'b0, inst_valid}, 64'd1);
    @(negedge clk);
    chk("hit_inst_valid", {63'b0, inst_valid},    64'd1);
    chk("hit_no_request", {63'b0, mem_req_valid}, 64'd0);
    @(negedge clk);
    chk("miss_req_valid", {63'b0, mem_req_valid}, 64'd1);
    chk("miss_req_addr",  mem_req_addr, 64'h8000_0008);
    lat = 6;

    // redirect while the response for 0x8000_0008 is outstanding
    @(negedge clk);
    chk("wait_req_low", {63'b0, mem_req_valid}, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0104;
    inst_ready     = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    lat            = 1;
    push(32'hAAAA0001, 64'h8000_0104);
    chk("single_outstanding", {63'b0, mem_req_valid}, 64'd0);
    wait_req("redirect_wait_addr", 64'h8000_0100);

    n = 0;
    while (!inst_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("redirect_inst_valid", {63'b0, inst_valid}, 64'd1);

    // backpressure: outputs held, no new request
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_inst",    {32'b0, inst},        {32'b0, 32'hAAAA0001});
      chk("bp_inst_pc", inst_pc,              64'h8000_0104);
      chk("bp_req_low", {63'b0, mem_req_valid}, 64'd0);
    end

    // redirect with simultaneous inst_ready in OUT; slow memory follows
    stall_left     = 3;
    lat            = 4;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0203;
    inst_ready     = 1'b1;
    push(32'h12345678, 64'h8000_0200);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("redir_out_valid_drop", {63'b0, inst_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_req_valid", {63'b0, mem_req_valid}, 64'd1);
      chk("stall_req_addr",  mem_req_addr, 64'h8000_0200);
    end
    @(negedge clk);
    chk("accept_req_valid", {63'b0, mem_req_valid}, 64'd1);
    chk("accept_req_addr",  mem_req_addr, 64'h8000_0200);
    push(32'h00000013, 64'h8000_0204);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("slow_latency", {63'b0, inst_valid}, (i == 5) ? 64'd1 : 64'd0);
    end

    // asynchronous reset while waiting for the response to 0x8000_0208
    wait_req("pre_reset_addr", 64'h8000_0208);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 reset_vals("async_reset");
    lat = 1;
    repeat (3) @(negedge clk);
    // the stale response is sampled on the first edge after this release
    #1 rst = 1'b1;
    push(32'h00100513, 64'h8000_0000);
    push(32'h00000297, 64'h8000_0004);
    push(32'h22222222, 64'h8000_0008);
    push(32'h11111111, 64'h8000_000C);
    @(negedge clk);
    chk("restart_req_valid", {63'b0, mem_req_valid}, 64'd1);
    chk("restart_req_addr",  mem_req_addr, 64'h8000_0000);
    chk("restart_no_inst",   {63'b0, inst_valid}, 64'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    inst_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
